stream_mux_tdm: RTL and testbench
=================================

// Module: stream_mux_tdm
// PURPOSE
//  Parametrised N-channel data-stream multiplexer; successor to the 3-stream symbol-rate mux.
//  Selects one of NCH input streams per symbol tick: idle, static select, fixed round-robin TDM, or skip-empty round-robin.
//  Registered output at symbol rate, with channel index and frame-start marker.
//  Sits between stream sources and the symbol-rate modulator/serialiser.
// PARAMETERS
//  NCH    3  number of input streams (>=2)
//  W      8  data width per stream
//  CNT_W  3  width of dwell count switch_clk_cycles
//  CH_W   $clog2(NCH)  channel index width (derived localparam, not overridable)
// PORTS
//  clk                in   1        system clock, all logic rising-edge
//  rst                in   1        synchronous reset, active-high
//  symbol_en          in   1        symbol-rate strobe, one clk wide; all state advances only when high
//  mode               in   2        00 idle, 01 static, 10 round-robin TDM, 11 skip-empty round-robin
//  sel                in   CH_W     static channel select (mode 01)
//  switch_clk_cycles  in   CNT_W    dwell per channel in symbol ticks; 0 treated as 1
//  in_data            in   NCH*W    packed streams, channel k = in_data[k*W +: W]
//  in_valid           in   NCH      per-channel data valid
//  output_data        out  W        selected data, registered
//  out_valid          out  1        registered valid of selected channel
//  out_chan           out  CH_W     registered index of selected channel
//  frame_start        out  1        one-symbol pulse on first tick of channel 0 slot (modes 10/11)
//  out_parity         out  1        even parity of output_data (see CONFIGURATION)
// BEHAVIOUR
//  Reset: output_data=0, out_valid=0, out_chan=0, frame_start=0, out_parity=0, cur=0, cnt=0, prev_mode=00.
//  Outputs update only on clk edges where symbol_en=1; otherwise hold. Latency: inputs sampled on symbol_en edge, visible after that edge.
//  Per tick, next_cur is computed, then output_data<=in_data[next_cur], out_valid<=in_valid[next_cur], out_chan<=next_cur.
//  mode 00: output_data=0, out_valid=0, out_chan=0, frame_start=0; cur and cnt cleared.
//  mode 01: next_cur=sel; sel>=NCH -> output_data=0, out_valid=0, out_chan=0. frame_start=0.
//  mode 10: entry tick (prev_mode!=10): next_cur=0, cnt=0, frame_start=1.
//   else if cnt==D-1 (D=max(switch_clk_cycles,1)): next_cur=(cur+1) mod NCH, cnt=0; else cnt++, next_cur=cur.
//   Slots fixed regardless of in_valid; out_valid mirrors in_valid[next_cur].
//  mode 11: as mode 10, but on slot change (and on entry) next_cur = first index from cur+1 (entry: from 0) wrapping with in_valid set.
//   No channel valid: output_data=0, out_valid=0, cur and out_chan hold, cnt held at 0; search repeats every tick.
//   Current channel dropping in_valid mid-dwell: dwell continues, out_valid=0 for those ticks.
//  frame_start=1 on any tick where next_cur==0 and cnt==0 in modes 10/11; otherwise 0.
//  Mode change takes effect on the next symbol tick only; prev_mode updates only on symbol ticks.
//  switch_clk_cycles changed mid-dwell: new D compared on the next tick; cnt>=D-1 forces a slot change.
//  Wrap: cur NCH-1 -> 0. cnt never exceeds 2^CNT_W-1.
//  rst overrides symbol_en; rst asserted mid-dwell returns all state to reset values on that edge.
// CONFIGURATION
//  STREAM_MUX_PARITY_EN defined: out_parity <= ^in_data[next_cur], registered with output_data; 0 whenever output_data forced 0.
//  STREAM_MUX_PARITY_EN undefined: out_parity tied 0, no parity logic.
// STRUCTURE
//  stream_mux_pkg: MODE_IDLE/MODE_STATIC/MODE_RR/MODE_RR_SKIP 2-bit localparams, mode_t typedef.
//  Sub-module stream_mux_rr_pick: combinational rotate-priority finder (in_valid, start index -> found, index).
//  Top: dwell counter, cur register, prev_mode register, output registers.
// TESTING
//  Streams: ch0=0x0F, ch1=0xCC, ch2=0x55, all valid, symbol_en every 6 clk unless stated.
//  1 Reset: rst=1 for 3 clk with symbol_en pulses -> all outputs 0; after release and mode 00 -> outputs stay 0.
//  2 mode 01, sel=1 -> output_data=0xCC, out_chan=1 after first tick; sel=3 -> output_data=0, out_valid=0.
//  3 mode 10, switch_clk_cycles=2 -> output 0x0F,0x0F,0xCC,0xCC,0x55,0x55,0x0F...; frame_start on ticks 1 and 7.
//  4 mode 10, switch_clk_cycles=0 -> channel changes every tick (D=1); mode change 10->01 applies on next tick only.
//  5 mode 11, D=1, in_valid=3'b101 -> output 0x0F,0x55,0x0F; in_valid=0 -> out_valid=0, output_data=0, out_chan held.
//  6 STREAM_MUX_PARITY_EN build, mode 01 sel=0 (0x0F) -> out_parity=0; ch0=0x07 -> out_parity=1; undefined build -> out_parity=0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared mode encodings for the TDM stream multiplexer.
package stream_mux_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_IDLE    = 2'b00;
   localparam mode_t MODE_STATIC  = 2'b01;
   localparam mode_t MODE_RR      = 2'b10;
   localparam mode_t MODE_RR_SKIP = 2'b11;

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Rotating-priority finder: first set bit of valid at or after start, wrapping.
module stream_mux_rr_pick #(
   parameter  int unsigned NCH  = 3,
   localparam int unsigned CH_W = $clog2(NCH)
) (
   input  logic [NCH-1:0]  valid,
   input  logic [CH_W-1:0] start,
   output logic            found_c,
   output logic [CH_W-1:0] idx_c
);

   localparam int unsigned PW = CH_W + 1;

   // Walk the channels from start with wrap; the first valid one wins.
   always_comb begin
      logic [PW-1:0]   pos;
      logic [CH_W-1:0] ch;
      found_c = 1'b0;
      idx_c   = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         pos = PW'(start) + PW'(i);
         if (pos >= PW'(NCH)) pos = pos - PW'(NCH);
         ch = CH_W'(pos);
         if (!found_c && valid[ch]) begin
            found_c = 1'b1;
            idx_c   = ch;
         end
      end
   end

endmodule

// File: rtl/stream_mux_tdm.sv
// N-channel symbol-rate stream mux: idle / static / round-robin TDM / skip-empty round-robin.
// Optional even-parity output enabled by defining STREAM_MUX_PARITY_EN.
module stream_mux_tdm
   import stream_mux_pkg::*;
#(
   parameter  int unsigned NCH   = 3,
   parameter  int unsigned W     = 8,
   parameter  int unsigned CNT_W = 3,
   localparam int unsigned CH_W  = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             symbol_en,
   input  logic [1:0]       mode,
   input  logic [CH_W-1:0]  sel,
   input  logic [CNT_W-1:0] switch_clk_cycles,
   input  logic [NCH*W-1:0] in_data,
   input  logic [NCH-1:0]   in_valid,
   output logic [W-1:0]     output_data,
   output logic             out_valid,
   output logic [CH_W-1:0]  out_chan,
   output logic             frame_start,
   output logic             out_parity
);

   logic [W-1:0]     ch_data [NCH];
   logic [CH_W-1:0]  cur_q, cur_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mode_t            prev_mode_q, prev_mode_d;
   logic             starve_q, starve_d;
   logic [W-1:0]     data_q, data_d;
   logic             valid_q, valid_d;
   logic             fs_q, fs_d;

   logic [CH_W-1:0]  cur_inc_c, rr_start_c, pick_idx_c, next_cur_c;
   logic [CNT_W-1:0] dwell_m1_c;
   logic             rr_entry_c, last_c, pick_found_c, zero_out_c;

   for (genvar k = 0; k < NCH; k++) begin : g_unpack
      assign ch_data[k] = in_data[k*W +: W];
   end

   // Slot bookkeeping: dwell end, entry detection and search start index.
   always_comb begin
      dwell_m1_c = (switch_clk_cycles == '0) ? '0 : switch_clk_cycles - CNT_W'(1);
      last_c     = (cnt_q >= dwell_m1_c);
      rr_entry_c = (prev_mode_q != mode);
      cur_inc_c  = (cur_q == CH_W'(NCH - 1)) ? '0 : cur_q + CH_W'(1);
      rr_start_c = rr_entry_c ? '0 : cur_inc_c;
   end

   stream_mux_rr_pick #(.NCH(NCH)) u_pick (
      .valid   (in_valid),
      .start   (rr_start_c),
      .found_c (pick_found_c),
      .idx_c   (pick_idx_c)
   );

   // Next-state and output selection, evaluated only on symbol ticks.
   always_comb begin
      cur_d       = cur_q;
      cnt_d       = cnt_q;
      prev_mode_d = prev_mode_q;
      starve_d    = starve_q;
      data_d      = data_q;
      valid_d     = valid_q;
      fs_d        = fs_q;
      next_cur_c  = cur_q;
      zero_out_c  = 1'b0;
      if (symbol_en) begin
         prev_mode_d = mode;
         fs_d        = 1'b0;
         starve_d    = 1'b0;
         case (mode)
            MODE_IDLE: begin
               next_cur_c = '0;
               cnt_d      = '0;
               zero_out_c = 1'b1;
            end
            MODE_STATIC: begin
               cnt_d = '0;
               if (32'(sel) < NCH) begin
                  next_cur_c = sel;
               end else begin
                  next_cur_c = '0;
                  zero_out_c = 1'b1;
               end
            end
            MODE_RR: begin
               if (rr_entry_c) begin
                  next_cur_c = '0;
                  cnt_d      = '0;
               end else if (last_c) begin
                  next_cur_c = cur_inc_c;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               fs_d = (next_cur_c == '0) && (cnt_d == '0);
            end
            MODE_RR_SKIP: begin
               if (rr_entry_c || last_c || starve_q) begin
                  cnt_d = '0;
                  if (pick_found_c) begin
                     next_cur_c = pick_idx_c;
                  end else begin
                     starve_d   = 1'b1;
                     zero_out_c = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               fs_d = (next_cur_c == '0) && (cnt_d == '0);
            end
         endcase
         cur_d   = next_cur_c;
         data_d  = zero_out_c ? '0 : ch_data[next_cur_c];
         valid_d = zero_out_c ? 1'b0 : in_valid[next_cur_c];
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q       <= '0;
         cnt_q       <= '0;
         prev_mode_q <= MODE_IDLE;
         starve_q    <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         fs_q        <= 1'b0;
      end else begin
         cur_q       <= cur_d;
         cnt_q       <= cnt_d;
         prev_mode_q <= prev_mode_d;
         starve_q    <= starve_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         fs_q        <= fs_d;
      end
   end

`ifdef STREAM_MUX_PARITY_EN
   logic par_q, par_d;

   // Even parity registered alongside the data; forced-zero data yields zero parity.
   always_comb begin
      par_d = par_q;
      if (symbol_en) par_d = ^data_d;
   end

   // Parity register.
   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end

   assign out_parity = par_q;
`else
   assign out_parity = 1'b0;
`endif

   // The channel register always tracks the reported channel.
   assign output_data = data_q;
   assign out_valid   = valid_q;
   assign out_chan    = cur_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_stream_mux_tdm.sv
// Scoreboard bench for stream_mux_tdm (default parameters, either parity build).
module tb_stream_mux_tdm;

   logic        clk = 1'b0;
   logic        rst;
   logic        symbol_en;
   logic [1:0]  mode;
   logic [1:0]  sel;
   logic [2:0]  switch_clk_cycles;
   logic [23:0] in_data;
   logic [2:0]  in_valid;
   logic [7:0]  output_data;
   logic        out_valid;
   logic [1:0]  out_chan;
   logic        frame_start;
   logic        out_parity;

   always #5 clk = ~clk;

   stream_mux_tdm #(.NCH(3), .W(8), .CNT_W(3)) dut (
      .clk               (clk),
      .rst               (rst),
      .symbol_en         (symbol_en),
      .mode              (mode),
      .sel               (sel),
      .switch_clk_cycles (switch_clk_cycles),
      .in_data           (in_data),
      .in_valid          (in_valid),
      .output_data       (output_data),
      .out_valid         (out_valid),
      .out_chan          (out_chan),
      .frame_start       (frame_start),
      .out_parity        (out_parity)
   );

   typedef struct {
      logic [7:0] d;
      logic       v;
      logic [1:0] c;
      logic       fs;
      logic       p;
      int         id;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_push = 0;

   function automatic logic exp_par(input logic [7:0] d);
`ifdef STREAM_MUX_PARITY_EN
      return ^d;
`else
      return 1'b0 & d[0];
`endif
   endfunction

   task automatic push(input logic [7:0] d, input logic v, input logic [1:0] c, input logic fs);
      exp_t e;
      e.d  = d;
      e.v  = v;
      e.c  = c;
      e.fs = fs;
      e.p  = exp_par(d);
      e.id = n_push;
      n_push++;
      sb_q.push_back(e);
   endtask

   // One symbol tick (one strobe edge, then five quiet edges), with its expected result.
   task automatic tick(input logic [7:0] d, input logic v, input logic [1:0] c, input logic fs);
      push(d, v, c, fs);
      symbol_en = 1'b1;
      @(negedge clk);
      symbol_en = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic set_streams(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
      in_data = {c2, c1, c0};
   endtask

   // Monitor: pop and compare on strobe edges, check hold on quiet edges.
   initial begin
      logic        se, r, have_last;
      logic [12:0] cur, last;
      exp_t        e;
      have_last = 1'b0;
      last      = '0;
      forever begin
         @(posedge clk);
         se = symbol_en;
         r  = rst;
         #1;
         cur = {output_data, out_valid, out_chan, frame_start, out_parity};
         if (se) begin
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_update got data=%h valid=%b chan=%0d", output_data, out_valid, out_chan);
            end else begin
               e = sb_q.pop_front();
               n_vec++;
               if (cur !== {e.d, e.v, e.c, e.fs, e.p}) begin
                  n_err++;
                  $display("FAIL vec#%0d got data=%h valid=%b chan=%0d fs=%b par=%b, expected data=%h valid=%b chan=%0d fs=%b par=%b",
                           e.id, output_data, out_valid, out_chan, frame_start, out_parity,
                           e.d, e.v, e.c, e.fs, e.p);
               end
            end
         end else if (!r && have_last) begin
            n_vec++;
            if (cur !== last) begin
               n_err++;
               $display("FAIL hold_between_ticks got %h expected %h", cur, last);
            end
         end
         last      = cur;
         have_last = 1'b1;
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog expired with %0d vectors pending", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst               = 1'b1;
      symbol_en         = 1'b0;
      mode              = 2'b00;
      sel               = 2'd0;
      switch_clk_cycles = 3'd2;
      in_valid          = 3'b111;
      set_streams(8'h0F, 8'hCC, 8'h55);
      repeat (2) @(negedge clk);

      // Reset with strobes present and a live static selection: outputs stay zero.
      mode = 2'b01;
      sel  = 2'd1;
      repeat (3) push(8'h00, 1'b0, 2'd0, 1'b0);
      symbol_en = 1'b1;
      repeat (3) @(negedge clk);
      rst       = 1'b0;
      symbol_en = 1'b0;
      mode      = 2'b00;
      repeat (4) @(negedge clk);
      tick(8'h00, 1'b0, 2'd0, 1'b0);
      tick(8'h00, 1'b0, 2'd0, 1'b0);

      // Static select, including out-of-range index.
      mode = 2'b01; sel = 2'd1;
      tick(8'hCC, 1'b1, 2'd1, 1'b0);
      tick(8'hCC, 1'b1, 2'd1, 1'b0);
      sel = 2'd3;
      tick(8'h00, 1'b0, 2'd0, 1'b0);
      sel = 2'd2;
      tick(8'h55, 1'b1, 2'd2, 1'b0);

      // Fixed TDM, dwell 2.
      mode = 2'b10; switch_clk_cycles = 3'd2;
      tick(8'h0F, 1'b1, 2'd0, 1'b1);
      tick(8'h0F, 1'b1, 2'd0, 1'b0);
      tick(8'hCC, 1'b1, 2'd1, 1'b0);
      tick(8'hCC, 1'b1, 2'd1, 1'b0);
      tick(8'h55, 1'b1, 2'd2, 1'b0);
      tick(8'h55, 1'b1, 2'd2, 1'b0);
      tick(8'h0F, 1'b1, 2'd0, 1'b1);
      tick(8'h0F, 1'b1, 2'd0, 1'b0);

      // Dwell 0 behaves as 1 and forces a change mid-dwell.
      switch_clk_cycles = 3'd0;
      tick(8'hCC, 1'b1, 2'd1, 1'b0);
      tick(8'h55, 1'b1, 2'd2, 1'b0);
      tick(8'h0F, 1'b1, 2'd0, 1'b1);
      mode = 2'b01; sel = 2'd1;
      tick(8'hCC, 1'b1, 2'd1, 1'b0);
      mode = 2'b10;
      tick(8'h0F, 1'b1, 2'd0, 1'b1);
      tick(8'hCC, 1'b1, 2'd1, 1'b0);

      // Skip-empty round-robin, dwell 1.
      mode = 2'b11; in_valid = 3'b101;
      tick(8'h0F, 1'b1, 2'd0, 1'b1);
      tick(8'h55, 1'b1, 2'd2, 1'b0);
      tick(8'h0F, 1'b1, 2'd0, 1'b1);
      tick(8'h55, 1'b1, 2'd2, 1'b0);
      in_valid = 3'b000;
      tick(8'h00, 1'b0, 2'd2, 1'b0);
      tick(8'h00, 1'b0, 2'd2, 1'b0);
      in_valid = 3'b010;
      tick(8'hCC, 1'b1, 2'd1, 1'b0);

      // Dwell 3 with the current channel dropping valid mid-dwell.
      in_valid = 3'b111; switch_clk_cycles = 3'd3;
      tick(8'hCC, 1'b1, 2'd1, 1'b0);
      in_valid = 3'b101;
      tick(8'hCC, 1'b0, 2'd1, 1'b0);
      in_valid = 3'b111;
      tick(8'h55, 1'b1, 2'd2, 1'b0);

      // Reset mid-dwell, then re-entry into TDM.
      mode = 2'b10;
      tick(8'h0F, 1'b1, 2'd0, 1'b1);
      tick(8'h0F, 1'b1, 2'd0, 1'b0);
      push(8'h00, 1'b0, 2'd0, 1'b0);
      rst = 1'b1; symbol_en = 1'b1;
      @(negedge clk);
      rst = 1'b0; symbol_en = 1'b0;
      repeat (5) @(negedge clk);
      tick(8'h0F, 1'b1, 2'd0, 1'b1);
      tick(8'h0F, 1'b1, 2'd0, 1'b0);
      mode = 2'b00;
      tick(8'h00, 1'b0, 2'd0, 1'b0);

      // Parity of the selected word.
      mode = 2'b01; sel = 2'd0;
      tick(8'h0F, 1'b1, 2'd0, 1'b0);
      set_streams(8'h07, 8'hCC, 8'h55);
      tick(8'h07, 1'b1, 2'd0, 1'b0);
      sel = 2'd2; set_streams(8'h07, 8'hCC, 8'h54);
      tick(8'h54, 1'b1, 2'd2, 1'b0);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_err += sb_q.size();
         $display("FAIL drain %0d vectors never observed, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
